// File: rtl/acp_pkg.sv
// Shared widths and the mixer sequencing state enum for the audio channel path.
package acp_pkg;
  localparam int WAVE_W = 4;
  localparam int VOL_W  = 2;
  localparam int MIX_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SCALE,
    OUT
  } mix_state_t;
endpackage

// File: rtl/acp_mixer_pwm_dac.sv
// 1-bit PWM DAC: free-running counter, duty reloaded only on wrap, registered compare.
module pwm_dac
  import acp_pkg::*;
#(
  parameter int W = MIX_W
) (
  input  logic         clk50mhz,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic         pwm_out
);

  logic [W-1:0] pwm_cnt;
  logic [W-1:0] duty;

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + W'(1);
      // Reload only at the 255->0 wrap so a period never sees two duty values
      if (pwm_cnt == '1) duty <= level;
      pwm_out <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/acp_mixer.sv
// Channel mixer: sample-rate divider, wave synchronizers, sequential weighted sum, PWM out.
// state | meaning
// IDLE  | wait for sample_tick, then snapshot inputs
// ACC   | add one channel term per cycle
// SCALE | apply master gain and saturate into mix_out
// OUT   | mix_valid pulse
module acp_mixer
  import acp_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_DIV = 1042,
  parameter int PWM_BITS   = 8
) (
  input  logic                     clk50mhz,
  input  logic                     rst,
  input  logic [WAVE_W*NUM_CH-1:0] ch_wave,
  input  logic [VOL_W*NUM_CH-1:0]  ch_vol,
  input  logic [NUM_CH-1:0]        ch_mute,
  input  logic [1:0]               master_vol,
  output logic                     sample_tick,
  output logic [MIX_W-1:0]         mix_out,
  output logic                     mix_valid,
  output logic                     clip,
  output logic                     pwm_out
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TERM_W = WAVE_W + VOL_W;
  localparam int SCL_W  = MIX_W + 2;

  logic [DIV_W-1:0]         div_cnt;
  logic [WAVE_W*NUM_CH-1:0] wave_meta, wave_sync, wave_snap;
  logic [VOL_W*NUM_CH-1:0]  vol_snap;
  logic [NUM_CH-1:0]        mute_snap;
  logic [1:0]               master_snap;
  logic [MIX_W-1:0]         acc;
  logic [IDX_W-1:0]         ch_idx;
  logic [WAVE_W-1:0]        cur_wave;
  logic [VOL_W-1:0]         cur_vol;
  logic [TERM_W-1:0]        term;
  logic [SCL_W-1:0]         prod, scaled;
  logic                     sat;
  mix_state_t               state, state_nx;
  logic                     snap_en, acc_en, out_en;

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(SAMPLE_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign sample_tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    cur_wave = wave_snap[ch_idx*WAVE_W +: WAVE_W];
    cur_vol  = vol_snap[ch_idx*VOL_W +: VOL_W];
    term     = mute_snap[ch_idx] ? '0 : TERM_W'(cur_wave) * TERM_W'(cur_vol);
  end

  // Gain is master_vol+1 in halves: 0.5x .. 2x
  assign prod   = SCL_W'(acc) * SCL_W'({1'b0, master_snap} + 3'd1);
  assign scaled = prod >> 1;
  assign sat    = |scaled[SCL_W-1:MIX_W];

  always_comb begin
    state_nx  = state;
    snap_en   = 1'b0;
    acc_en    = 1'b0;
    out_en    = 1'b0;
    mix_valid = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          snap_en  = 1'b1;
          state_nx = ACC;
        end
      end
      ACC: begin
        acc_en = 1'b1;
        if (ch_idx == IDX_W'(NUM_CH - 1)) state_nx = SCALE;
      end
      SCALE: begin
        out_en   = 1'b1;
        state_nx = OUT;
      end
      OUT: begin
        mix_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wave_meta   <= '0;
      wave_sync   <= '0;
      wave_snap   <= '0;
      vol_snap    <= '0;
      mute_snap   <= '0;
      master_snap <= '0;
      acc         <= '0;
      ch_idx      <= '0;
      mix_out     <= '0;
      clip        <= 1'b0;
    end else begin
      state     <= state_nx;
      wave_meta <= ch_wave;
      wave_sync <= wave_meta;
      if (snap_en) begin
        wave_snap   <= wave_sync;
        vol_snap    <= ch_vol;
        mute_snap   <= ch_mute;
        master_snap <= master_vol;
        acc         <= '0;
        ch_idx      <= '0;
      end
      if (acc_en) begin
        acc    <= acc + MIX_W'(term);
        ch_idx <= ch_idx + IDX_W'(1);
      end
      if (out_en) begin
        mix_out <= sat ? '1 : scaled[MIX_W-1:0];
        clip    <= sat;
      end
    end
  end

  pwm_dac #(.W(PWM_BITS)) u_pwm_dac (
    .clk50mhz (clk50mhz),
    .rst      (rst),
    .level    (mix_out),
    .pwm_out  (pwm_out)
  );

endmodule

// File: tb/tb_acp_mixer.sv
// Directed bench for acp_mixer: scoreboard of expected samples plus a cycle model of the PWM.
module tb_acp_mixer;
  localparam int NC = 4;
  localparam int SD = 40;

  logic          clk50mhz = 1'b0;
  logic          rst = 1'b1;
  logic [4*NC-1:0] ch_wave = '0;
  logic [2*NC-1:0] ch_vol = '0;
  logic [NC-1:0] ch_mute = '0;
  logic [1:0]    master_vol = '0;
  logic          sample_tick, mix_valid, clip, pwm_out;
  logic [7:0]    mix_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int mix;
    int clp;
    int t;
  } exp_t;
  exp_t sb[$];

  int cyc = 0, last_tick = 0, exp_mix_now = 0, exp_clip_now = 0;
  int m_cnt = 0, m_duty = 0, m_pwm = 0;

  acp_mixer #(.NUM_CH(NC), .SAMPLE_DIV(SD), .PWM_BITS(8)) dut (
    .clk50mhz    (clk50mhz),
    .rst         (rst),
    .ch_wave     (ch_wave),
    .ch_vol      (ch_vol),
    .ch_mute     (ch_mute),
    .master_vol  (master_vol),
    .sample_tick (sample_tick),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .clip        (clip),
    .pwm_out     (pwm_out)
  );

  always #10 clk50mhz = ~clk50mhz;

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int model_mix();
    int a;
    a = 0;
    for (int k = 0; k < NC; k++)
      if (!ch_mute[k]) a += int'(ch_wave[4*k +: 4]) * int'(ch_vol[2*k +: 2]);
    return (a * (int'(master_vol) + 1)) / 2;
  endfunction

  always @(negedge clk50mhz) begin
    exp_t e;
    int v;
    cyc++;
    if (rst) begin
      chk("reset_outputs", int'({sample_tick, mix_valid, clip, pwm_out, mix_out}), 0);
      sb.delete();
      last_tick = cyc;
      m_cnt = 0; m_duty = 0; m_pwm = 0;
      exp_mix_now = 0; exp_clip_now = 0;
    end else begin
      chk("pwm_out", int'(pwm_out), m_pwm);
      if (sample_tick) begin
        chk("tick_period", cyc - last_tick, SD);
        last_tick = cyc;
        v = model_mix();
        sb.push_back('{mix: (v > 255) ? 255 : v, clp: (v > 255) ? 1 : 0, t: cyc});
      end
      if (sb.size() > 0 && cyc - sb[0].t > 6) begin
        chk("valid_latency_timeout", cyc - sb[0].t, 6);
        void'(sb.pop_front());
      end
      if (mix_valid) begin
        chk("sb_nonempty_on_valid", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("valid_latency", cyc - e.t, 6);
          chk("mix_out", int'(mix_out), e.mix);
          chk("clip", int'(clip), e.clp);
          exp_mix_now = e.mix;
          exp_clip_now = e.clp;
        end
      end
      chk("mix_out_hold", int'(mix_out), exp_mix_now);
      chk("clip_hold", int'(clip), exp_clip_now);
      m_pwm = (m_cnt < m_duty) ? 1 : 0;
      if (m_cnt == 255) m_duty = exp_mix_now;
      m_cnt = (m_cnt + 1) % 256;
    end
  end

  task automatic set_ch(input int k, input int w, input int vv, input bit m);
    ch_wave[4*k +: 4] = 4'(w);
    ch_vol[2*k +: 2]  = 2'(vv);
    ch_mute[k]        = m;
  endtask

  task automatic set_all(input int w, input int vv, input bit m);
    for (int k = 0; k < NC; k++) set_ch(k, w, vv, m);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk50mhz);
      n++;
    end while (!mix_valid && n < SD + 20);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk50mhz);
      n++;
    end while (!sample_tick && n < SD + 20);
  endtask

  task automatic count_high(output int h);
    h = 0;
    repeat (256) begin
      @(negedge clk50mhz);
      h += int'(pwm_out);
    end
  endtask

  task automatic next_inputs();
    @(posedge clk50mhz);
    #1;
  endtask

  initial begin
    int n, h;
    rst = 1'b1;
    set_ch(0, 15, 3, 1'b0);
    for (int k = 1; k < NC; k++) set_ch(k, 0, 0, 1'b1);
    master_vol = 2'd1;
    repeat (3) @(posedge clk50mhz);
    #1 rst = 1'b0;

    // single channel 15*3 -> 45
    wait_valid(n);
    chk("first_valid_delay", n, SD + 6);

    // all channels max, master 3 -> 360 clipped
    next_inputs();
    set_all(15, 3, 1'b0);
    master_vol = 2'd3;
    wait_valid(n);
    chk("valid_seen_clip", int'(mix_valid), 1);

    // reset in the middle of ACC, then master 0 -> 90
    next_inputs();
    master_vol = 2'd0;
    wait_tick(n);
    chk("tick_seen", int'(sample_tick), 1);
    @(posedge clk50mhz);
    @(posedge clk50mhz);
    #1 rst = 1'b1;
    #1 chk("rst_async_outputs", int'({sample_tick, mix_valid, clip, pwm_out, mix_out}), 0);
    repeat (3) @(posedge clk50mhz);
    #1 rst = 1'b0;
    wait_valid(n);
    chk("valid_after_reset", n, SD + 6);

    // zero volume and mute
    next_inputs();
    set_ch(0, 0, 3, 1'b0);
    set_ch(1, 0, 3, 1'b0);
    set_ch(2, 15, 0, 1'b0);
    set_ch(3, 15, 3, 1'b1);
    master_vol = 2'd3;
    wait_valid(n);
    chk("valid_seen_mute", int'(mix_valid), 1);

    // 45 + 15 + 4 = 64 at master 1
    next_inputs();
    set_ch(0, 15, 3, 1'b0);
    set_ch(1, 15, 1, 1'b0);
    set_ch(2, 4, 1, 1'b0);
    set_ch(3, 0, 0, 1'b1);
    master_vol = 2'd1;
    wait_valid(n);
    repeat (300) @(negedge clk50mhz);
    count_high(h);
    chk("pwm_high_64", h, 64);

    wait_valid(n);
    next_inputs();
    set_all(15, 3, 1'b0);
    master_vol = 2'd3;
    wait_valid(n);
    repeat (300) @(negedge clk50mhz);
    count_high(h);
    chk("pwm_high_255", h, 255);

    wait_valid(n);
    next_inputs();
    set_all(15, 3, 1'b1);
    wait_valid(n);
    repeat (300) @(negedge clk50mhz);
    count_high(h);
    chk("pwm_high_0", h, 0);

    // snapshot isolation: wave 8 -> 0 while ACC is running
    wait_valid(n);
    next_inputs();
    set_ch(0, 8, 3, 1'b0);
    master_vol = 2'd1;
    wait_tick(n);
    @(posedge clk50mhz);
    @(posedge clk50mhz);
    #1 set_ch(0, 0, 3, 1'b0);
    wait_valid(n);
    chk("snap_current", int'(mix_out), 24);
    wait_valid(n);
    chk("snap_next", int'(mix_out), 0);

    repeat (10) @(negedge clk50mhz);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acp_mixer.md
# acp_mixer

Mixes the 4-bit `wave_out` streams of all synth channels (square, noise, etc.) into one 8-bit sample at a fixed audio rate and drives a 1-bit PWM DAC pin. It sits directly downstream of every channel's envelope stage and is the last block before the board's audio output filter. It runs entirely in the 50 MHz domain. Channel inputs come from BUFG-derived note clocks, so it resynchronizes them before use.

## Interface
Parameters:
- `NUM_CH`, 4: number of channel inputs.
- `SAMPLE_DIV`, 1042: clk50mhz cycles per output sample (≈48 kHz). Must be ≥ NUM_CH+4.
- `PWM_BITS`, 8: PWM counter and mix width. Fixed at 8 in this revision.

Ports:
- `clk50mhz` in 1: system clock. Single clock for the block.
- `rst` in 1: reset, asynchronous, active-high.
- `ch_wave` in 4*NUM_CH: channel samples, channel k at [4k+3:4k].
- `ch_vol` in 2*NUM_CH: per-channel weight 0..3, channel k at [2k+1:2k].
- `ch_mute` in NUM_CH: per-channel mute, 1 = contributes 0.
- `master_vol` in 2: master gain select 0..3.
- `sample_tick` out 1: one-cycle pulse at each sample instant.
- `mix_out` out 8: current mixed sample.
- `mix_valid` out 1: one-cycle pulse when `mix_out` updates.
- `clip` out 1: high while the current `mix_out` was saturated.
- `pwm_out` out 1: PWM DAC output.

## Operation
- **Input sync:** every `ch_wave` bit passes through a 2-flop synchronizer. `ch_vol`, `ch_mute` and `master_vol` are quasi-static and sampled directly.
- **Divider:** counts 0..SAMPLE_DIV-1 and wraps. `sample_tick`=1 in the cycle the count equals SAMPLE_DIV-1.
- **FSM states:** IDLE, ACC, SCALE, OUT.
  - IDLE: on `sample_tick`, snapshot all synced `ch_wave`, `ch_vol`, `ch_mute` and `master_vol`, clear the accumulator and channel index, then go to ACC.
  - ACC: one channel per cycle, index 0..NUM_CH-1. term = mute ? 0 : wave*vol (6 bits, max 45). The accumulator is 8 bits (max 180) and never overflows. After the last channel, go to SCALE.
  - SCALE: scaled = (acc * (master_vol+1)) >> 1, 10-bit intermediate, max 360. Then go to OUT.
  - OUT: if scaled > 255, then `mix_out`=255 and `clip`=1; else `mix_out`=scaled[7:0] and `clip`=0. `mix_valid`=1 for this one cycle. Then go to IDLE.
- Input changes after the snapshot do not affect the sample in progress.
- A `sample_tick` that arrives outside IDLE cannot occur, given the SAMPLE_DIV constraint. If it does, it is ignored.
- **PWM:** a free-running 8-bit `pwm_cnt`. `duty` reloads from `mix_out` only when `pwm_cnt` wraps 255→0, so there is never a mid-period change. `pwm_out` is registered (`pwm_cnt` < `duty`).
  - duty 0 gives a constant 0.
  - duty 255 gives 255 high cycles per 256.
- **Reset (any time, including mid-ACC):**
  - Outputs: `sample_tick`, `mix_valid`, `clip`, `pwm_out` = 0 and `mix_out` = 0.
  - Internal state: divider, `pwm_cnt`, `duty`, accumulator and synchronizers = 0; FSM = IDLE.
  - The first tick after release comes SAMPLE_DIV cycles later.

## Timing
- Tick at cycle T; snapshot at T; ACC occupies T+1..T+NUM_CH; SCALE at T+NUM_CH+1; OUT at T+NUM_CH+2.
- `mix_valid`, `mix_out` and `clip` are visible from T+NUM_CH+2 (T+6 for 4 channels). `mix_out` holds until the next OUT.
- A `ch_wave` change reaches the snapshot 2 cycles later (synchronizer delay). A change is captured only if it is stable at least 2 cycles before the tick.
- PWM period is 256 cycles (195.3 kHz). A new `mix_out` reaches `pwm_out` at the next wrap plus 1 cycle of register delay.

## Structure
- Shared package `acp_pkg` holds:
  - width constants WAVE_W=4, VOL_W=2, MIX_W=8;
  - the mixer FSM state enum (IDLE/ACC/SCALE/OUT), reusable by later channel-sequencing blocks.
- One sub-module is natural: `pwm_dac`, containing the counter, the wrap-aligned duty register and the compare.
- Divider, synchronizers, FSM and datapath stay in `acp_mixer`.

## Test plan
- **Reset mid-operation:** assert `rst` during ACC → all outputs 0 immediately; no `mix_valid` until SAMPLE_DIV+6 cycles after release.
- **Single channel:** ch0 wave=15, vol=3, ch1-3 muted, master=1 → `mix_out`=45, `clip`=0, `mix_valid` exactly 6 cycles after `sample_tick`.
- **All channels at max:** wave=15, vol=3, master=3 → scaled 360, so `mix_out`=255 and `clip`=1. Same inputs with master=0 → 90, `clip`=0.
- **Mute and zero volume:** ch2 wave=15 with vol=0, ch3 wave=15 with mute=1, others 0 → `mix_out`=0.
- **Snapshot isolation:** change `ch_wave` from 8 to 0 during ACC → the current sample uses 8 and the next sample uses 0.
- **PWM:** `mix_out`=64 → over one aligned 256-cycle period `pwm_out` is high exactly 64 cycles. `mix_out`=0 → `pwm_out` stays low. A change in `mix_out` mid-period takes effect only after the wrap.
